// File: rtl/tagged_data_memory.sv
// ============================================================================
//  Module      : tagged_data_memory
//  Description : Byte/half/word data memory with one CHERI validity tag per
//                word, fault reporting and a post-reset clearing sweep.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tagged_data_memory #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter bit          CLEAR_DATA = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic                  req_wtag,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_rtag,
    output logic [1:0]            resp_fault,
    output logic                  init_done
);

    localparam int unsigned IW       = $clog2(DEPTH);
    localparam logic [IW:0] LAST_IDX = (IW + 1)'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IW:0]    idx_q, idx_d;
    logic [31:0]    mem_q [DEPTH];
    logic           tag_q [DEPTH];

    logic           resp_valid_q, resp_valid_d;
    logic [31:0]    resp_rdata_q, resp_rdata_d;
    logic           resp_rtag_q,  resp_rtag_d;
    logic [1:0]     resp_fault_q, resp_fault_d;

    logic           sweep_we;
    logic           accept;
    logic           store_we;
    logic [IW-1:0]  widx;
    logic [1:0]     lane;
    logic           is_byte, is_half, is_word;
    logic           misaligned, out_of_range;
    logic [1:0]     fault_code;
    logic [3:0]     byte_en;
    logic [31:0]    wmask, wdata_rep, rd_word, merged, shifted;
    logic [15:0]    half_val;

    // Sweep state: one word cleared per cycle while held out of reset
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sweep_we = 1'b0;
        if (state_q == ST_INIT && !rst) begin
            sweep_we = 1'b1;
            idx_d    = idx_q + (IW + 1)'(1);
            if (idx_q == LAST_IDX) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign req_ready = (state_q == ST_READY) && !rst;
    assign init_done = (state_q == ST_READY);
    assign accept    = req_valid && req_ready;

    assign widx    = req_addr[IW+1:2];
    assign lane    = req_addr[1:0];
    assign is_byte = (req_size == 2'b00);
    assign is_half = (req_size == 2'b01);
    assign is_word = req_size[1];

    assign misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));

    generate
        if (ADDR_WIDTH > IW + 2) begin : g_range
            assign out_of_range = |req_addr[ADDR_WIDTH-1:IW+2];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign fault_code = misaligned   ? 2'b01 :
                        out_of_range ? 2'b10 : 2'b00;

    assign store_we = accept && req_write && (fault_code == 2'b00);

    always_comb begin
        byte_en   = 4'b1111;
        wdata_rep = req_wdata;
        if (is_byte) begin
            byte_en   = 4'b0001 << lane;
            wdata_rep = {4{req_wdata[7:0]}};
        end else if (is_half) begin
            byte_en   = lane[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{req_wdata[15:0]}};
        end
    end

    assign wmask   = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
    assign rd_word = mem_q[widx];
    assign merged  = (rd_word & ~wmask) | (wdata_rep & wmask);

    // Any sub-word store invalidates the capability held in that word
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            if (CLEAR_DATA) begin
                mem_q[idx_q[IW-1:0]] <= '0;
            end
            tag_q[idx_q[IW-1:0]] <= 1'b0;
        end else if (store_we) begin
            mem_q[widx] <= merged;
            tag_q[widx] <= is_word & req_wtag;
        end
    end

    assign shifted  = rd_word >> {lane, 3'b000};
    assign half_val = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        resp_valid_d = accept;
        resp_rdata_d = '0;
        resp_rtag_d  = 1'b0;
        resp_fault_d = accept ? fault_code : 2'b00;
        if (accept && !req_write && fault_code == 2'b00) begin
            if (is_byte) begin
                resp_rdata_d = req_unsigned ? {24'd0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            end else if (is_half) begin
                resp_rdata_d = req_unsigned ? {16'd0, half_val}
                                            : {{16{half_val[15]}}, half_val};
            end else begin
                resp_rdata_d = rd_word;
                resp_rtag_d  = tag_q[widx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_rtag_q  <= 1'b0;
            resp_fault_q <= 2'b00;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_rtag_q  <= resp_rtag_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_rtag  = resp_rtag_q;
    assign resp_fault = resp_fault_q;

endmodule

`default_nettype wire

// File: tb/tb_tagged_data_memory.sv
// ============================================================================
//  Module      : tb_tagged_data_memory
//  Description : Scoreboard bench for tagged_data_memory (DEPTH=256).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tagged_data_memory;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_wtag;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_rtag;
    logic [1:0]  resp_fault;
    logic        init_done;

    tagged_data_memory #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (32),
        .CLEAR_DATA (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wtag     (req_wtag),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_rtag    (resp_rtag),
        .resp_fault   (resp_fault),
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        rtag;
        logic [1:0]  fault;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Responses are compared against the oldest pending expectation
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_cycle", cyc, e.cyc);
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_rtag", {31'd0, resp_rtag}, {31'd0, e.rtag});
                chk("resp_fault", {30'd0, resp_fault}, {30'd0, e.fault});
            end
        end
    end

    // Called just after a rising edge; the request is accepted on the next one
    task automatic req(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic wt,
                       input logic [31:0] e_rdata, input logic e_rtag, input logic [1:0] e_fault);
        exp_t e;
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_wtag     = wt;
        e.rdata = e_rdata;
        e.rtag  = e_rtag;
        e.fault = e_fault;
        e.cyc   = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_init(input string tag);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 2 * DEPTH) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, n, DEPTH);
        chk({tag, "_done"}, {31'd0, init_done}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_wtag     = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_rtag", {31'd0, resp_rtag}, 32'd0);
        chk("rst_fault", {30'd0, resp_fault}, 32'd0);

        // Hold a word load at 0x0 through the sweep; it must not be taken early
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b1;
        count_init("init_len");

        //   w     sz     uns   addr          wdata         wt    e_rdata       e_rtag e_fault
        req(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 32'h0000_0000, 1'b0, 2'b00);
        req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 1'b1, 32'h0000_0000, 1'b0, 2'b00);
        req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 2'b00);
        req(1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_0080, 1'b1, 32'h0,        1'b0, 2'b00);
        req(1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,        1'b0, 32'hFFFF_FF80, 1'b0, 2'b00);
        req(1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,        1'b0, 32'h0000_80EF, 1'b0, 2'b00);
        req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEAD80EF, 1'b0, 2'b00);
        idle(2);
        req(1'b1, 2'b10, 1'b0, 32'h0000_0012, 32'h1111_1111, 1'b1, 32'h0,        1'b0, 2'b01);
        req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEAD80EF, 1'b0, 2'b00);
        req(1'b0, 2'b01, 1'b0, 32'h0000_0013, 32'h0,        1'b0, 32'h0,        1'b0, 2'b01);
        req(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h1234_5678, 1'b1, 32'h0,        1'b0, 2'b10);
        req(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 32'h0,        1'b0, 2'b00);
        req(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0,        1'b0, 32'h0,        1'b0, 2'b10);
        req(1'b0, 2'b10, 1'b0, 32'h0000_0401, 32'h0,        1'b0, 32'h0,        1'b0, 2'b01);
        req(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h5555_ABCD, 1'b1, 32'h0,        1'b0, 2'b00);
        req(1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0,        1'b0, 32'hFFFF_ABCD, 1'b0, 2'b00);
        req(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        1'b0, 32'hABCD_0000, 1'b0, 2'b00);
        req(1'b1, 2'b10, 1'b0, 32'h0000_0024, 32'h1122_3344, 1'b1, 32'h0,        1'b0, 2'b00);
        req(1'b0, 2'b00, 1'b1, 32'h0000_0027, 32'h0,        1'b0, 32'h0000_0011, 1'b0, 2'b00);
        req(1'b0, 2'b00, 1'b0, 32'h0000_0026, 32'h0,        1'b0, 32'h0000_0022, 1'b0, 2'b00);
        req(1'b0, 2'b11, 1'b0, 32'h0000_0024, 32'h0,        1'b0, 32'h1122_3344, 1'b1, 2'b00);
        req(1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'h8765_4321, 1'b1, 32'h0,        1'b0, 2'b00);
        req(1'b1, 2'b00, 1'b0, 32'h0000_0033, 32'h0000_00FF, 1'b0, 32'h0,        1'b0, 2'b00);
        req(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0,        1'b0, 32'hFF65_4321, 1'b0, 2'b00);
        req(1'b0, 2'b00, 1'b0, 32'h0000_0030, 32'h0,        1'b0, 32'h0000_0021, 1'b0, 2'b00);

        // Reset on the edge right after a load acceptance
        req(1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'h0,        1'b0, 32'h1122_3344, 1'b1, 2'b00);
        rst       = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst_init_done", {31'd0, init_done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_init("reinit_len");

        req(1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'h0,        1'b0, 32'h0,        1'b0, 2'b00);
        req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'h0,        1'b0, 2'b00);
        idle(3);
        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
